// File: rtl/pet_pkg.sv
// Shared definitions for the pet action scheduler: action indices, FSM
// state encoding and the fixed per-need decay schedule.
package pet_pkg;

  // Action / request bit positions
  localparam int ACT_FEED  = 0;
  localparam int ACT_SLEEP = 1;
  localparam int ACT_PLAY  = 2;
  localparam int ACT_HEAL  = 3;
  localparam int N_ACT     = 4;

  // Decay bit positions {happy,fun,sleep,food}
  localparam int DCY_FOOD  = 0;
  localparam int DCY_SLEEP = 1;
  localparam int DCY_FUN   = 2;
  localparam int DCY_HAPPY = 3;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  // Seconds within the period at which each need decays
  localparam logic [6:0] SCH_FOOD  [3] = '{7'd30, 7'd60, 7'd0};
  localparam logic [6:0] SCH_SLEEP [3] = '{7'd18, 7'd49, 7'd86};
  localparam logic [6:0] SCH_FUN   [4] = '{7'd25, 7'd50, 7'd73, 7'd89};
  localparam logic [6:0] SCH_HAPPY [4] = '{7'd23, 7'd47, 7'd69, 7'd83};

  // Which needs are scheduled to decay at a given second
  function automatic logic [3:0] decay_hit(input logic [6:0] sec);
    logic [3:0] hit;
    hit = '0;
    for (int k = 0; k < 3; k++) begin
      if (sec == SCH_FOOD[k])  hit[DCY_FOOD]  = 1'b1;
      if (sec == SCH_SLEEP[k]) hit[DCY_SLEEP] = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      if (sec == SCH_FUN[k])   hit[DCY_FUN]   = 1'b1;
      if (sec == SCH_HAPPY[k]) hit[DCY_HAPPY] = 1'b1;
    end
    return hit;
  endfunction

  // Index of the set bit in a one-hot 4-bit vector
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < N_ACT; k++) begin
      if (oh[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pet_rr_arbiter.sv
// Combinational 4-way round-robin arbiter. The search starts one past the
// last granted index. With PET_HEAL_PRIORITY_EN defined, a pending heal
// request always wins and the rotation covers only feed/sleep/play.
module pet_rr_arbiter
  import pet_pkg::*;
(
  input  logic [3:0] pending_i,
  input  logic [1:0] last_i,
  output logic [3:0] grant_o
);

  logic [3:0] cand;
  logic [1:0] idx;
  logic       found;

  // Pick the first candidate after last_i, wrapping mod 4
  always_comb begin
    cand    = pending_i;
    grant_o = '0;
    found   = 1'b0;
    idx     = 2'd0;
`ifdef PET_HEAL_PRIORITY_EN
    if (pending_i[ACT_HEAL]) begin
      grant_o[ACT_HEAL] = 1'b1;
      found             = 1'b1;
    end
    cand[ACT_HEAL] = 1'b0;
`endif
    for (int k = 1; k <= N_ACT; k++) begin
      idx = last_i + 2'(k);
      if (!found && cand[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pet_action_scheduler.sv
// Timebase and action scheduler: 1 s tick, second-in-period counter, scheduled
// decay pulses, and cooldown-gated round-robin granting of user requests.
// Optional build macro PET_HEAL_PRIORITY_EN gives heal absolute priority.
module pet_action_scheduler
  import pet_pkg::*;
#(
  parameter int FREQ       = 50,
  parameter int PERIOD_S   = 90,
  parameter int COOLDOWN_S = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       dead,
  output logic [3:0] grant,
  output logic       busy,
  output logic       tick_1s,
  output logic [6:0] sec_count,
  output logic [3:0] decay
);

  localparam int              PW        = (FREQ > 1) ? $clog2(FREQ) : 1;
  localparam int              CW        = (COOLDOWN_S > 1) ? $clog2(COOLDOWN_S + 1) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(FREQ - 1);
  localparam logic [6:0]      SEC_MAX   = 7'(PERIOD_S - 1);
  localparam logic [CW-1:0]   CD_INIT   = CW'(COOLDOWN_S);
  localparam logic [CW-1:0]   CD_LAST   = CW'(1);

  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic [6:0]    sec_q;
  logic [3:0]    decay_q;
  logic [3:0]    req_prev_q;
  logic [3:0]    req_rise;
  logic [3:0]    pending_q;
  logic [3:0]    pending_d;
  logic [3:0]    arb_sel;
  state_e        state_q;
  logic [1:0]    last_q;
  logic [CW-1:0] cd_q;
  logic [3:0]    grant_q;
  logic          busy_q;

  // Prescaler, one-second tick and wrapping second counter; never halted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      sec_q   <= '0;
    end else begin
      tick_q  <= (presc_q == PRESC_MAX);
      presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
      if (tick_q) begin
        sec_q <= (sec_q == SEC_MAX) ? 7'd0 : sec_q + 7'd1;
      end
    end
  end

  // Decay pulses follow the tick by one cycle, suppressed once halted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      decay_q <= '0;
    end else begin
      decay_q <= (tick_q && state_q != ST_HALT) ? decay_hit(sec_q) : 4'b0000;
    end
  end

  // Per-request rising-edge capture; the granted bit clears in its grant
  // cycle unless a fresh edge arrives in that same cycle
  for (genvar gi = 0; gi < N_ACT; gi++) begin : g_req
    assign req_rise[gi]  = req[gi] & ~req_prev_q[gi];
    assign pending_d[gi] = (state_q == ST_HALT) ? 1'b0
                         : ((pending_q[gi] & ~grant_q[gi]) | req_rise[gi]);
  end

  // Request history and pending set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      req_prev_q <= req;
      pending_q  <= pending_d;
    end
  end

  pet_rr_arbiter u_arb (
    .pending_i (pending_q),
    .last_i    (last_q),
    .grant_o   (arb_sel)
  );

  // Grant FSM with registered grant/busy; dead is terminal until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd3;
      cd_q    <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          grant_q <= '0;
          if (dead) begin
            state_q <= ST_HALT;
            busy_q  <= 1'b0;
          end else if (|pending_q) begin
            state_q <= ST_GRANT;
            grant_q <= arb_sel;
            busy_q  <= 1'b1;
          end
        end
        ST_GRANT: begin
          grant_q <= '0;
          cd_q    <= CD_INIT;
`ifdef PET_HEAL_PRIORITY_EN
          if (!grant_q[ACT_HEAL]) last_q <= onehot_to_idx(grant_q);
`else
          last_q  <= onehot_to_idx(grant_q);
`endif
          if (dead) begin
            state_q <= ST_HALT;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_COOLDOWN;
            busy_q  <= 1'b1;
          end
        end
        ST_COOLDOWN: begin
          grant_q <= '0;
          if (dead) begin
            state_q <= ST_HALT;
            busy_q  <= 1'b0;
          end else if (tick_q) begin
            if (cd_q == CD_LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cd_q <= cd_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_HALT;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign tick_1s   = tick_q;
  assign sec_count = sec_q;
  assign decay     = decay_q;

endmodule

// File: tb/tb_pet_action_scheduler.sv
// Self-checking bench for pet_action_scheduler (FREQ=4, PERIOD_S=90,
// COOLDOWN_S=3). Expectations come from the timing and arbitration rules.
module tb_pet_action_scheduler;

  localparam int FREQ       = 4;
  localparam int PERIOD_S   = 90;
  localparam int COOLDOWN_S = 3;
  localparam int GAP_MIN    = (COOLDOWN_S - 1) * FREQ;      // exclusive
  localparam int GAP_MAX    = COOLDOWN_S * FREQ + 2;        // inclusive

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       dead = 1'b0;
  logic [3:0] grant;
  logic       busy;
  logic       tick_1s;
  logic [6:0] sec_count;
  logic [3:0] decay;

  pet_action_scheduler #(
    .FREQ       (FREQ),
    .PERIOD_S   (PERIOD_S),
    .COOLDOWN_S (COOLDOWN_S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dead      (dead),
    .grant     (grant),
    .busy      (busy),
    .tick_1s   (tick_1s),
    .sec_count (sec_count),
    .decay     (decay)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] first;
    int         ngrants;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Outputs are sampled on the falling edge; inputs change right after
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req  = 4'b0000;
    dead = 1'b0;
    rst  = 1'b0;
    step();
    step();
    rst  = 1'b1;
  endtask

  task automatic pulse(input logic [3:0] r);
    req = r;
    step();
    req = 4'b0000;
  endtask

  task automatic wait_grant(input int maxc, output logic [3:0] g, output int c);
    g = 4'b0000;
    c = 0;
    while (c < maxc) begin
      step();
      c++;
      if (grant != 4'b0000) begin
        g = grant;
        break;
      end
    end
  endtask

  // Needs scheduled to decay at second s, straight from the schedule lists
  function automatic logic [3:0] model_decay(input int s);
    logic [3:0] d;
    d[0] = (s == 30 || s == 60 || s == 0);
    d[1] = (s == 18 || s == 49 || s == 86);
    d[2] = (s == 25 || s == 50 || s == 73 || s == 89);
    d[3] = (s == 23 || s == 47 || s == 69 || s == 83);
    return d;
  endfunction

  // Next winner: first pending action after the last one served
  function automatic logic [3:0] model_pick(input logic [3:0] p, input int last);
    logic [3:0] q;
    q = p;
`ifdef PET_HEAL_PRIORITY_EN
    if (q[3]) return 4'b1000;
    q[3] = 1'b0;
`endif
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (q[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  function automatic int model_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  initial begin
    logic [3:0] g;
    int         c;

    // Vectors applied back to back after the in-order sequence (last=2)
    vecs[0] = '{4'b0001, 4'b0001, 1};
    vecs[1] = '{4'b0010, 4'b0010, 1};
    vecs[2] = '{4'b1000, 4'b1000, 1};
    vecs[3] = '{4'b0100, 4'b0100, 1};
    vecs[4] = '{4'b1001, 4'b1000, 2};
    vecs[5] = '{4'b0110, 4'b0010, 2};
    vecs[6] = '{4'b0011, 4'b0001, 2};

    // ---- reset state, then free-running timebase over a full period ----
    rst = 1'b0;
    step();
    step();
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_busy",  32'(busy), 32'(0));
    check("rst_tick",  32'(tick_1s), 32'(0));
    check("rst_sec",   32'(sec_count), 32'(0));
    check("rst_decay", 32'(decay), 32'(0));
    rst = 1'b1;
    begin
      int  esec;
      int  ptick;
      logic [3:0] edec;
      esec  = 0;
      ptick = 0;
      for (int n = 1; n <= FREQ * (PERIOD_S + 1) + 2; n++) begin
        step();
        edec = (ptick != 0) ? model_decay(esec) : 4'b0000;
        if (ptick != 0) esec = (esec + 1) % PERIOD_S;
        check("tb_tick",  32'(tick_1s), 32'((n % FREQ) == 0));
        check("tb_sec",   32'(sec_count), 32'(esec));
        check("tb_decay", 32'(decay), 32'(edec));
        check("tb_grant", 32'(grant), 32'(0));
        ptick = ((n % FREQ) == 0) ? 1 : 0;
      end
      $display("timebase: %0d cycles, sec_count now %0d", FREQ * (PERIOD_S + 1) + 2, sec_count);
    end

    // ---- three held requests: served in order, no repeats ----
    begin
      logic [3:0] gs [$];
      int         ts [$];
      req = 4'b0111;
      for (int n = 1; n <= 60; n++) begin
        step();
        if (grant != 4'b0000) begin
          gs.push_back(grant);
          ts.push_back(n);
        end
      end
      req = 4'b0000;
      check("seq_count", 32'(gs.size()), 32'(3));
      if (gs.size() == 3) begin
        check("seq_g0", 32'(gs[0]), 32'(4'b0001));
        check("seq_g1", 32'(gs[1]), 32'(4'b0010));
        check("seq_g2", 32'(gs[2]), 32'(4'b0100));
        check("seq_lat", 32'(ts[0]), 32'(2));
        for (int i = 1; i < 3; i++) begin
          check("seq_gap", 32'((ts[i] - ts[i-1]) > GAP_MIN && (ts[i] - ts[i-1]) <= GAP_MAX), 32'(1));
        end
      end
      $display("in-order: %0d grants seen", gs.size());
    end
    step();

    // ---- table-driven single/multi request vectors ----
    for (int v = 0; v < 7; v++) begin
      int cnt;
      req = vecs[v].req;
      step();
      req = 4'b0000;
      step();
      check("vec_first", 32'(grant), 32'(vecs[v].first));
      check("vec_busy",  32'(busy), 32'(1));
      cnt = (grant != 4'b0000) ? 1 : 0;
      for (int n = 0; n < 40; n++) begin
        step();
        if (grant != 4'b0000) cnt++;
      end
      check("vec_count", 32'(cnt), 32'(vecs[v].ngrants));
      check("vec_idle",  32'(busy), 32'(0));
      $display("vec %0d: req=%b first=%b grants=%0d", v, vecs[v].req, vecs[v].first, cnt);
    end

    // ---- feed and heal together ----
    do_reset();
    pulse(4'b1001);
    step();
`ifdef PET_HEAL_PRIORITY_EN
    check("heal_first",  32'(grant), 32'(4'b1000));
    wait_grant(20, g, c);
    check("heal_second", 32'(g), 32'(4'b0001));
`else
    check("heal_first",  32'(grant), 32'(4'b0001));
    wait_grant(20, g, c);
    check("heal_second", 32'(g), 32'(4'b1000));
`endif
    $display("feed+heal: second grant %b after %0d cycles", g, c);
    for (int n = 0; n < 20; n++) step();

    // ---- asynchronous reset in the middle of a cooldown ----
    pulse(4'b0001);
    wait_grant(10, g, c);
    check("mid_grant", 32'(g), 32'(4'b0001));
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'(0));
    check("arst_busy",  32'(busy), 32'(0));
    check("arst_tick",  32'(tick_1s), 32'(0));
    check("arst_sec",   32'(sec_count), 32'(0));
    check("arst_decay", 32'(decay), 32'(0));
    step();
    rst = 1'b1;
    pulse(4'b0010);
    step();
    check("arst_regrant", 32'(grant), 32'(4'b0010));
    $display("reset mid-cooldown: regrant %b", grant);
    for (int n = 0; n < 20; n++) step();

    // ---- randomized requests against the reference model ----
    begin
      logic [3:0] mpend, mgprev, rprev, r, eg;
      int         mlast, lastg, waitc, ngr;
      do_reset();
      mpend  = 4'b0000;
      mgprev = 4'b0000;
      rprev  = 4'b0000;
      mlast  = 3;
      lastg  = -1;
      waitc  = 0;
      ngr    = 0;
      for (int t = 1; t <= 3000; t++) begin
        r = rprev;
        for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
        req = r;
        step();
        eg = 4'b0000;
        if (grant != 4'b0000) begin
          eg = model_pick(mpend, mlast);
          check("rnd_grant", 32'(grant), 32'(eg));
          if (lastg >= 0) begin
            check("rnd_gap", 32'((t - lastg) > GAP_MIN && (t - lastg) <= GAP_MAX), 32'(1));
          end
`ifdef PET_HEAL_PRIORITY_EN
          if (!eg[3]) mlast = model_idx(eg);
`else
          mlast = model_idx(eg);
`endif
          lastg = t;
          waitc = 0;
          ngr++;
        end else if (mpend != 4'b0000) begin
          waitc++;
          if (waitc == GAP_MAX + 1) begin
            check("rnd_starve", 32'(waitc), 32'(GAP_MAX));
            waitc = 0;
          end
        end
        mpend  = (mpend & ~mgprev) | (r & ~rprev);
        mgprev = eg;
        rprev  = r;
      end
      req = 4'b0000;
      $display("random: %0d grants in 3000 cycles", ngr);
    end

    // ---- dead during cooldown: halted, timebase keeps running ----
    do_reset();
    pulse(4'b0001);
    wait_grant(10, g, c);
    check("halt_pre_grant", 32'(g), 32'(4'b0001));
    step();
    step();
    dead = 1'b1;
    step();
    step();
    check("halt_busy", 32'(busy), 32'(0));
    begin
      int ng, nd, nt;
      ng = 0;
      nd = 0;
      nt = 0;
      for (int n = 0; n < 25 * FREQ; n++) begin
        req = 4'($urandom_range(15));
        step();
        if (grant != 4'b0000) ng++;
        if (decay != 4'b0000) nd++;
        if (tick_1s) nt++;
      end
      check("halt_grants", 32'(ng), 32'(0));
      check("halt_decays", 32'(nd), 32'(0));
      check("halt_ticks",  32'(nt), 32'(25));
      check("halt_busy2",  32'(busy), 32'(0));
      $display("halt: grants=%0d decays=%0d ticks=%0d", ng, nd, nt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
